// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: issues word requests at the current PC, holds the
// returned instruction for decode, and squashes in-flight fetches on redirect.
module instruction_fetch #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic [WORD_SIZE-1:0] pc_in,
  output logic                 inc_pc,
  output logic                 load_pc,
  output logic [WORD_SIZE-1:0] pc_data,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_addr,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 instr_valid,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] instr_pc,
  input  logic                 instr_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t               state_r;
  logic                 mem_req_r;
  logic                 instr_valid_r;
  logic [WORD_SIZE-1:0] mem_addr_r;
  logic [WORD_SIZE-1:0] instr_r;
  logic [WORD_SIZE-1:0] instr_pc_r;
  logic                 inc_pc_s;

  // PC increment fires in the ack cycle of a live fetch; gated by rst so reset blocks it without a clock
  always_comb begin
    inc_pc_s = 1'b0;
    if (rst && (state_r == REQ) && mem_ack && !redirect) begin
      inc_pc_s = 1'b1;
    end else begin
      inc_pc_s = 1'b0;
    end
  end

  // Fetch FSM with registered memory request, address and instruction outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      mem_req_r     <= 1'b0;
      instr_valid_r <= 1'b0;
      mem_addr_r    <= {WORD_SIZE{1'b0}};
      instr_r       <= {WORD_SIZE{1'b0}};
      instr_pc_r    <= {WORD_SIZE{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (fetch_en && !redirect) begin
            state_r    <= REQ;
            mem_req_r  <= 1'b1;
            mem_addr_r <= pc_in;
          end
        end
        REQ: begin
          if (redirect) begin
            // An unacked request cannot be withdrawn, so its response is drained in DISCARD
            if (mem_ack) begin
              state_r   <= IDLE;
              mem_req_r <= 1'b0;
            end else begin
              state_r <= DISCARD;
            end
          end else if (mem_ack) begin
            state_r       <= HOLD;
            mem_req_r     <= 1'b0;
            instr_valid_r <= 1'b1;
            instr_r       <= mem_rdata;
            instr_pc_r    <= mem_addr_r;
          end
        end
        HOLD: begin
          if (redirect) begin
            state_r       <= IDLE;
            instr_valid_r <= 1'b0;
          end else if (instr_ready) begin
            instr_valid_r <= 1'b0;
            if (fetch_en) begin
              state_r    <= REQ;
              mem_req_r  <= 1'b1;
              mem_addr_r <= pc_in;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          mem_req_r     <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign inc_pc      = inc_pc_s;
  assign load_pc     = redirect;
  assign pc_data     = redirect_addr;
  assign mem_req     = mem_req_r;
  assign mem_addr    = mem_addr_r;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small program-counter model on pc_in.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [15:0] pc_in;
  logic        inc_pc;
  logic        load_pc;
  logic [15:0] pc_data;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [15:0] pc_init;
  int          errors = 0;
  int          checks = 0;

  instruction_fetch #(.WORD_SIZE(16)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_in(pc_in),
    .inc_pc(inc_pc), .load_pc(load_pc), .pc_data(pc_data),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Program counter model: load on redirect, otherwise increment on request
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_in <= pc_init;
    else if (load_pc) pc_in <= pc_data;
    else if (inc_pc) pc_in <= pc_in + 16'd1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 16'h0000; instr_ready = 1'b0; pc_init = 16'h0010;
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    chk("rst_inc_pc", {15'd0, inc_pc}, 16'd0);
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b1;
    cyc();
    // Scenario 1: basic fetch at 0x0010
    chk("s1_req", {15'd0, mem_req}, 16'd1);
    chk("s1_addr", mem_addr, 16'h0010);
    chk("s1_noinc", {15'd0, inc_pc}, 16'd0);
    cyc();
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    #1;
    chk("s1_inc", {15'd0, inc_pc}, 16'd1);
    chk("s1_addr_stable", mem_addr, 16'h0010);
    cyc();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    #1;
    chk("s1_inc_once", {15'd0, inc_pc}, 16'd0);
    chk("s1_valid", {15'd0, instr_valid}, 16'd1);
    chk("s1_instr", instr, 16'hA5A5);
    chk("s1_instr_pc", instr_pc, 16'h0010);
    chk("s1_req_off", {15'd0, mem_req}, 16'd0);
    // Scenario 2: decode stalls three cycles
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s2_valid", {15'd0, instr_valid}, 16'd1);
      chk("s2_instr", instr, 16'hA5A5);
      chk("s2_noreq", {15'd0, mem_req}, 16'd0);
    end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("s2_next_req", {15'd0, mem_req}, 16'd1);
    chk("s2_next_addr", mem_addr, 16'h0011);
    chk("s2_valid_off", {15'd0, instr_valid}, 16'd0);
    // Scenario 3: redirect before ack
    redirect = 1'b1; redirect_addr = 16'h0200;
    #1;
    chk("s3_load", {15'd0, load_pc}, 16'd1);
    chk("s3_pc_data", pc_data, 16'h0200);
    chk("s3_noinc", {15'd0, inc_pc}, 16'd0);
    cyc();
    redirect = 1'b0;
    #1;
    chk("s3_req_held", {15'd0, mem_req}, 16'd1);
    chk("s3_addr_held", mem_addr, 16'h0011);
    chk("s3_load_off", {15'd0, load_pc}, 16'd0);
    cyc();
    chk("s3_req_held2", {15'd0, mem_req}, 16'd1);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    chk("s3_ack_noinc", {15'd0, inc_pc}, 16'd0);
    cyc();
    mem_ack = 1'b0;
    chk("s3_idle_req", {15'd0, mem_req}, 16'd0);
    chk("s3_no_valid", {15'd0, instr_valid}, 16'd0);
    chk("s3_dropped", instr, 16'hA5A5);
    chk("s3_pc", pc_in, 16'h0200);
    cyc();
    chk("s3_new_req", {15'd0, mem_req}, 16'd1);
    chk("s3_new_addr", mem_addr, 16'h0200);
    // Scenario 4: redirect coincident with ack
    mem_ack = 1'b1; mem_rdata = 16'h1234; redirect = 1'b1; redirect_addr = 16'h0300;
    #1;
    chk("s4_noinc", {15'd0, inc_pc}, 16'd0);
    chk("s4_load", {15'd0, load_pc}, 16'd1);
    cyc();
    mem_ack = 1'b0; redirect = 1'b0;
    chk("s4_no_valid", {15'd0, instr_valid}, 16'd0);
    chk("s4_idle_req", {15'd0, mem_req}, 16'd0);
    chk("s4_dropped", instr, 16'hA5A5);
    cyc();
    chk("s4_req", {15'd0, mem_req}, 16'd1);
    chk("s4_addr", mem_addr, 16'h0300);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    #1;
    chk("s4_inc", {15'd0, inc_pc}, 16'd1);
    cyc();
    mem_ack = 1'b0;
    chk("s4_valid", {15'd0, instr_valid}, 16'd1);
    chk("s4_instr", instr, 16'h5A5A);
    chk("s4_instr_pc", instr_pc, 16'h0300);
    // Scenario 5: redirect together with instr_ready in HOLD
    redirect = 1'b1; redirect_addr = 16'h0400; instr_ready = 1'b1;
    #1;
    chk("s5_noinc", {15'd0, inc_pc}, 16'd0);
    cyc();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("s5_valid_off", {15'd0, instr_valid}, 16'd0);
    chk("s5_idle_req", {15'd0, mem_req}, 16'd0);
    chk("s5_addr_kept", mem_addr, 16'h0300);
    cyc();
    chk("s5_req", {15'd0, mem_req}, 16'd1);
    chk("s5_addr", mem_addr, 16'h0400);
    // Scenario 6: reset mid-request, even with an ack in flight
    pc_init = 16'h0050;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    chk("s6_inc", {15'd0, inc_pc}, 16'd0);
    chk("s6_req", {15'd0, mem_req}, 16'd0);
    chk("s6_addr", mem_addr, 16'h0000);
    chk("s6_valid", {15'd0, instr_valid}, 16'd0);
    chk("s6_instr", instr, 16'h0000);
    chk("s6_instr_pc", instr_pc, 16'h0000);
    mem_ack = 1'b0;
    cyc();
    chk("s6_held_req", {15'd0, mem_req}, 16'd0);
    rst = 1'b1;
    cyc();
    chk("s6_fresh_req", {15'd0, mem_req}, 16'd1);
    chk("s6_fresh_addr", mem_addr, 16'h0050);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    #1;
    chk("s6_inc_fresh", {15'd0, inc_pc}, 16'd1);
    cyc();
    mem_ack = 1'b0;
    chk("s6_instr_fresh", instr, 16'h7777);
    chk("s6_instr_pc_fresh", instr_pc, 16'h0050);
    // fetch_en low with ready: retire to IDLE
    fetch_en = 1'b0; instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    chk("fe_idle_valid", {15'd0, instr_valid}, 16'd0);
    chk("fe_idle_req", {15'd0, mem_req}, 16'd0);
    // Redirect in IDLE stays IDLE, then fetch from 0xFFFF and wrap to 0x0000
    fetch_en = 1'b1; redirect = 1'b1; redirect_addr = 16'hFFFF;
    cyc();
    redirect = 1'b0;
    chk("ri_idle_req", {15'd0, mem_req}, 16'd0);
    cyc();
    chk("wrap_req", {15'd0, mem_req}, 16'd1);
    chk("wrap_addr", mem_addr, 16'hFFFF);
    mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    cyc();
    mem_ack = 1'b0; instr_ready = 1'b1;
    chk("wrap_instr_pc", instr_pc, 16'hFFFF);
    cyc();
    instr_ready = 1'b0; fetch_en = 1'b0;
    chk("wrap_next_addr", mem_addr, 16'h0000);
    cyc();
    chk("fe_no_abort", {15'd0, mem_req}, 16'd1);
    chk("fe_addr_stable", mem_addr, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
